// File: rtl/brp_resolve_queue.sv
// In-order queue of in-flight branch predictions.
// Scores the oldest entry on resolve and flushes on mispredict.
module brp_resolve_queue #(
  parameter int DEPTH = 8,
  parameter int PC_W  = 32,
  parameter int CNT_W = 32,
  localparam int AW   = $clog2(DEPTH),
  localparam int CW   = AW + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [PC_W-1:0]  push_pc,
  input  logic             push_pred,
  output logic             full,
  output logic             empty,
  output logic [CW-1:0]    count,
  input  logic             resolve,
  input  logic [PC_W-1:0]  resolve_pc,
  input  logic             resolve_taken,
  input  logic             flush,
  output logic             bp_load,
  output logic             bp_correctness,
  output logic             mispredict,
  output logic [PC_W-1:0]  mispredict_pc,
  output logic [CNT_W-1:0] branch_cnt,
  output logic [CNT_W-1:0] mispred_cnt,
  output logic             err_overflow,
  output logic             err_underflow,
  output logic             err_order
);

  typedef struct packed {
    logic [PC_W-1:0] pc;
    logic            pred;
  } entry_t;

  entry_t          mem [DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  entry_t          head;
  logic            res_ok;
  logic            push_ok;
  logic            correct;
  logic            mis;
  logic            clear;

  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);
  assign head  = mem[rd_ptr];

  // Accept/score decisions for this cycle
  always_comb begin
    res_ok  = resolve && !empty;
    push_ok = push && (!full || res_ok);
    correct = (head.pred == resolve_taken);
    mis     = res_ok && !correct;
    clear   = flush || mis;
  end

  // Entry storage; wrong-path pushes are never written
  always_ff @(posedge clk) begin
    if (push_ok && !clear)
      mem[wr_ptr] <= '{pc: push_pc, pred: push_pred};
  end

  // Pointers and occupancy; mispredict or flush empties the queue
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok)
        wr_ptr <= wr_ptr + AW'(1);
      if (res_ok)
        rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(push_ok) - CW'(res_ok);
    end
  end

  // Registered predictor strobes and mispredict report
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bp_load        <= 1'b0;
      bp_correctness <= 1'b0;
      mispredict     <= 1'b0;
      mispredict_pc  <= '0;
    end else begin
      bp_load        <= res_ok;
      bp_correctness <= res_ok && correct;
      mispredict     <= mis;
      if (mis)
        mispredict_pc <= head.pc;
    end
  end

  // Saturating statistics
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      branch_cnt  <= '0;
      mispred_cnt <= '0;
    end else begin
      if (res_ok && branch_cnt != '1)
        branch_cnt <= branch_cnt + CNT_W'(1);
      if (mis && mispred_cnt != '1)
        mispred_cnt <= mispred_cnt + CNT_W'(1);
    end
  end

  // Sticky protocol errors
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      err_overflow  <= 1'b0;
      err_underflow <= 1'b0;
      err_order     <= 1'b0;
    end else begin
      if (push && full && !res_ok)
        err_overflow <= 1'b1;
      if (resolve && empty)
        err_underflow <= 1'b1;
      if (res_ok && resolve_pc != head.pc)
        err_order <= 1'b1;
    end
  end

endmodule

// File: tb/tb_brp_resolve_queue.sv
// Directed bench for brp_resolve_queue.
// DEPTH=8, PC_W=32, CNT_W=4 so saturation is reachable.
module tb_brp_resolve_queue;

  logic        clk = 1'b0;
  logic        rst;
  logic        push;
  logic [31:0] push_pc;
  logic        push_pred;
  logic        full;
  logic        empty;
  logic [3:0]  count;
  logic        resolve;
  logic [31:0] resolve_pc;
  logic        resolve_taken;
  logic        flush;
  logic        bp_load;
  logic        bp_correctness;
  logic        mispredict;
  logic [31:0] mispredict_pc;
  logic [3:0]  branch_cnt;
  logic [3:0]  mispred_cnt;
  logic        err_overflow;
  logic        err_underflow;
  logic        err_order;

  int checks = 0;
  int errors = 0;

  brp_resolve_queue #(
    .DEPTH(8),
    .PC_W(32),
    .CNT_W(4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .push(push),
    .push_pc(push_pc),
    .push_pred(push_pred),
    .full(full),
    .empty(empty),
    .count(count),
    .resolve(resolve),
    .resolve_pc(resolve_pc),
    .resolve_taken(resolve_taken),
    .flush(flush),
    .bp_load(bp_load),
    .bp_correctness(bp_correctness),
    .mispredict(mispredict),
    .mispredict_pc(mispredict_pc),
    .branch_cnt(branch_cnt),
    .mispred_cnt(mispred_cnt),
    .err_overflow(err_overflow),
    .err_underflow(err_underflow),
    .err_order(err_order)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic drv(input logic p, input logic [31:0] ppc,
                     input logic pp, input logic r,
                     input logic [31:0] rpc, input logic rt,
                     input logic f);
    push          = p;
    push_pc       = ppc;
    push_pred     = pp;
    resolve       = r;
    resolve_pc    = rpc;
    resolve_taken = rt;
    flush         = f;
    @(posedge clk);
    #1;
    push    = 1'b0;
    resolve = 1'b0;
    flush   = 1'b0;
  endtask

  task automatic do_push(input logic [31:0] pc, input logic pr);
    drv(1'b1, pc, pr, 1'b0, 32'h0, 1'b0, 1'b0);
  endtask

  task automatic do_res(input logic [31:0] pc, input logic t);
    drv(1'b0, 32'h0, 1'b0, 1'b1, pc, t, 1'b0);
  endtask

  task automatic idle();
    drv(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
  endtask

  initial begin
    rst = 1'b0;
    push = 1'b0; push_pc = '0; push_pred = 1'b0;
    resolve = 1'b0; resolve_pc = '0; resolve_taken = 1'b0;
    flush = 1'b0;
    #12;
    check("rst_count", count, 0);
    check("rst_empty", empty, 1);
    check("rst_full", full, 0);
    check("rst_bp_load", bp_load, 0);
    check("rst_bcnt", branch_cnt, 0);
    check("rst_errs", {err_overflow, err_underflow, err_order}, 0);
    rst = 1'b1;

    // 1: simple correct prediction
    do_push(32'h100, 1'b1);
    check("t1_count1", count, 1);
    do_res(32'h100, 1'b1);
    check("t1_load", bp_load, 1);
    check("t1_corr", bp_correctness, 1);
    check("t1_mis", mispredict, 0);
    check("t1_bcnt", branch_cnt, 1);
    check("t1_count0", count, 0);
    idle();
    check("t1_load_off", {bp_load, bp_correctness}, 0);

    // 2: fill, overflow, push+resolve while full, wrap drain
    for (int i = 0; i < 8; i++)
      do_push(32'h20 + 32'(i * 4), 1'b1);
    check("t2_full", full, 1);
    check("t2_count8", count, 8);
    do_push(32'h999, 1'b1);
    check("t2_drop_count", count, 8);
    check("t2_ovf", err_overflow, 1);
    drv(1'b1, 32'h40, 1'b1, 1'b1, 32'h20, 1'b1, 1'b0);
    check("t2_pr_count", count, 8);
    check("t2_pr_load", {bp_load, bp_correctness}, 2'b11);
    for (int i = 1; i < 9; i++) begin
      do_res(32'h20 + 32'(i * 4), 1'b1);
      check($sformatf("t2_drain%0d", i), {bp_load, bp_correctness}, 2'b11);
    end
    check("t2_order_ok", err_order, 0);
    check("t2_empty", empty, 1);
    check("t2_bcnt", branch_cnt, 10);

    // 3: mispredict flushes younger entries and same-cycle push
    do_push(32'h10, 1'b1);
    do_push(32'h14, 1'b0);
    do_push(32'h18, 1'b1);
    check("t3_count3", count, 3);
    drv(1'b1, 32'h50, 1'b1, 1'b1, 32'h10, 1'b0, 1'b0);
    check("t3_mis", mispredict, 1);
    check("t3_load", {bp_load, bp_correctness}, 2'b10);
    check("t3_mpc", mispredict_pc, 32'h10);
    check("t3_count0", count, 0);
    check("t3_mcnt", mispred_cnt, 1);
    idle();
    check("t3_mis_off", mispredict, 0);
    check("t3_mpc_hold", mispredict_pc, 32'h10);
    do_push(32'h60, 1'b1);
    do_res(32'h60, 1'b1);
    check("t3_after", {bp_load, bp_correctness, mispredict}, 3'b110);
    check("t3_order_ok", err_order, 0);

    // 4: underflow and order error
    do_res(32'h300, 1'b1);
    check("t4_uf_load", bp_load, 0);
    check("t4_uf", err_underflow, 1);
    check("t4_bcnt", branch_cnt, 12);
    do_push(32'h204, 1'b1);
    do_res(32'h200, 1'b1);
    check("t4_order", err_order, 1);
    check("t4_pop_load", bp_load, 1);
    check("t4_pop_count", count, 0);
    drv(1'b1, 32'h210, 1'b1, 1'b1, 32'h210, 1'b1, 1'b0);
    check("t4_ufpush_count", count, 1);
    check("t4_ufpush_load", bp_load, 0);
    do_res(32'h210, 1'b1);
    check("t4_bcnt14", branch_cnt, 14);

    // 5: flush overrides push; flush with resolve still scores
    do_push(32'h70, 1'b1);
    do_push(32'h74, 1'b1);
    do_push(32'h78, 1'b1);
    drv(1'b1, 32'h7C, 1'b1, 1'b0, 32'h0, 1'b0, 1'b1);
    check("t5_fl_count", count, 0);
    check("t5_fl_load", bp_load, 0);
    do_push(32'h80, 1'b1);
    drv(1'b0, 32'h0, 1'b0, 1'b1, 32'h80, 1'b1, 1'b1);
    check("t5_flr_load", {bp_load, bp_correctness}, 2'b11);
    check("t5_flr_count", count, 0);
    check("t5_bcnt15", branch_cnt, 15);

    // 6: saturation of both counters
    for (int i = 0; i < 16; i++) begin
      do_push(32'h400 + 32'(i * 4), 1'b0);
      do_res(32'h400 + 32'(i * 4), 1'b1);
      if (i == 13)
        check("t6_mcnt15", mispred_cnt, 15);
    end
    check("t6_bsat", branch_cnt, 4'hF);
    check("t6_msat", mispred_cnt, 4'hF);
    check("t6_mpc", mispredict_pc, 32'h43C);

    // async reset mid-stream
    do_push(32'h500, 1'b1);
    do_push(32'h504, 1'b1);
    #2;
    rst = 1'b0;
    #1;
    check("ar_count", count, 0);
    check("ar_empty", empty, 1);
    check("ar_cnts", {branch_cnt, mispred_cnt}, 0);
    check("ar_mpc", mispredict_pc, 0);
    check("ar_errs", {err_overflow, err_underflow, err_order}, 0);
    check("ar_strobes", {bp_load, bp_correctness, mispredict}, 0);
    #2;
    rst = 1'b1;
    idle();
    check("ar_post_count", count, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
